// File: rtl/mmu_sequencer_if.sv
// Command and memory-side bundle for the matrix-multiply sequencer.
// The host drives the command fields; the sequencer drives status and memory strobes.
interface mmu_sequencer_if #(
   parameter int WIDTH_HEIGHT = 4,
   parameter int ADDR_W       = 8
);
   localparam int ROW_W = (WIDTH_HEIGHT > 1) ? $clog2(WIDTH_HEIGHT) : 1;

   logic                           start;
   logic [ADDR_W-1:0]              num_rows;
   logic [ADDR_W-1:0]              base_in_addr;
   logic [ADDR_W-1:0]              base_out_addr;
   logic [ADDR_W-1:0]              base_wt_addr;
   logic                           busy;
   logic                           done;
   logic                           wt_en;
   logic [ROW_W-1:0]               wt_row;
   logic [ADDR_W-1:0]              wt_addr;
   logic [WIDTH_HEIGHT-1:0]        rd_en;
   logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr;
   logic [WIDTH_HEIGHT-1:0]        wr_en;
   logic [WIDTH_HEIGHT*ADDR_W-1:0] wr_addr;

   modport master (
      output start, num_rows, base_in_addr, base_out_addr, base_wt_addr,
      input  busy, done, wt_en, wt_row, wt_addr, rd_en, rd_addr, wr_en, wr_addr
   );

   modport slave (
      input  start, num_rows, base_in_addr, base_out_addr, base_wt_addr,
      output busy, done, wt_en, wt_row, wt_addr, rd_en, rd_addr, wr_en, wr_addr
   );
endinterface

// File: rtl/mmu_sequencer.sv
// Schedules one systolic matrix-multiply pass: weight preload, skewed input
// streaming and skewed output writeback, then a one-cycle done pulse.
module mmu_seq_lane #(
   parameter int LANE      = 0,
   parameter int ADDR_W    = 8,
   parameter int ARRAY_LAT = 4,
   parameter int CW        = 10
) (
   input  logic              run_i,
   input  logic [CW-1:0]     t_i,
   input  logic [CW-1:0]     nr_i,
   input  logic [ADDR_W-1:0] base_in_i,
   input  logic [ADDR_W-1:0] base_out_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o
);
   localparam logic [CW-1:0] RD0 = CW'(LANE);
   localparam logic [CW-1:0] WR0 = CW'(LANE + ARRAY_LAT);

   // Lane k sees the same schedule as lane 0, shifted k cycles later.
   always_comb begin
      rd_en_o   = run_i && (t_i >= RD0) && (t_i < RD0 + nr_i);
      wr_en_o   = run_i && (t_i >= WR0) && (t_i < WR0 + nr_i);
      rd_addr_o = rd_en_o ? base_in_i  + ADDR_W'(t_i - RD0) : '0;
      wr_addr_o = wr_en_o ? base_out_i + ADDR_W'(t_i - WR0) : '0;
   end
endmodule

module mmu_sequencer #(
   parameter int WIDTH_HEIGHT = 4,
   parameter int ADDR_W       = 8,
   parameter int ARRAY_LAT    = 4
) (
   input  logic             clk,
   input  logic             reset,
   mmu_sequencer_if.slave   bus
);
   localparam int ROW_W = (WIDTH_HEIGHT > 1) ? $clog2(WIDTH_HEIGHT) : 1;
   // Wide enough for num_rows + ARRAY_LAT + WIDTH_HEIGHT at the largest num_rows.
   localparam int CW    = ADDR_W + 2 + $clog2(ARRAY_LAT + WIDTH_HEIGHT + 1);

   typedef enum logic [1:0] {IDLE, WLOAD, RUN, DONE} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] nr_q, nr_d;
   logic [ADDR_W-1:0] bin_q, bin_d;
   logic [ADDR_W-1:0] bout_q, bout_d;
   logic [ADDR_W-1:0] bwt_q, bwt_d;
   logic [CW-1:0]     nr_ext;
   logic [CW-1:0]     t_last;
   logic              run;

   assign nr_ext = CW'(nr_q);
   assign t_last = nr_ext + CW'(ARRAY_LAT + WIDTH_HEIGHT - 2);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         nr_q    <= '0;
         bin_q   <= '0;
         bout_q  <= '0;
         bwt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nr_q    <= nr_d;
         bin_q   <= bin_d;
         bout_q  <= bout_d;
         bwt_q   <= bwt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nr_d    = nr_q;
      bin_d   = bin_q;
      bout_d  = bout_q;
      bwt_d   = bwt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.start && (bus.num_rows != '0)) begin
               state_d = WLOAD;
               nr_d    = bus.num_rows;
               bin_d   = bus.base_in_addr;
               bout_d  = bus.base_out_addr;
               bwt_d   = bus.base_wt_addr;
            end
         end
         WLOAD: begin
            if (cnt_q == CW'(WIDTH_HEIGHT - 1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            if (cnt_q == t_last) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      bus.busy    = (state_q != IDLE);
      bus.done    = (state_q == DONE);
      bus.wt_en   = (state_q == WLOAD);
      bus.wt_row  = bus.wt_en ? cnt_q[ROW_W-1:0] : '0;
      bus.wt_addr = bus.wt_en ? bwt_q + ADDR_W'(cnt_q) : '0;
      run         = (state_q == RUN);
   end

   logic [WIDTH_HEIGHT-1:0]             rd_en_w, wr_en_w;
   logic [WIDTH_HEIGHT-1:0][ADDR_W-1:0] rd_addr_w, wr_addr_w;

   for (genvar k = 0; k < WIDTH_HEIGHT; k++) begin : g_lane
      mmu_seq_lane #(
         .LANE      (k),
         .ADDR_W    (ADDR_W),
         .ARRAY_LAT (ARRAY_LAT),
         .CW        (CW)
      ) u_lane (
         .run_i      (run),
         .t_i        (cnt_q),
         .nr_i       (nr_ext),
         .base_in_i  (bin_q),
         .base_out_i (bout_q),
         .rd_en_o    (rd_en_w[k]),
         .rd_addr_o  (rd_addr_w[k]),
         .wr_en_o    (wr_en_w[k]),
         .wr_addr_o  (wr_addr_w[k])
      );
   end

   assign bus.rd_en   = rd_en_w;
   assign bus.rd_addr = rd_addr_w;
   assign bus.wr_en   = wr_en_w;
   assign bus.wr_addr = wr_addr_w;
endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer: records each pass cycle by cycle and
// compares against hand-computed schedules.
module tb_mmu_sequencer;
   localparam int NC = 20;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mmu_sequencer_if #(.WIDTH_HEIGHT(4), .ADDR_W(8)) bus ();

   mmu_sequencer #(.WIDTH_HEIGHT(4), .ADDR_W(8), .ARRAY_LAT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   logic        r_busy [0:NC];
   logic        r_done [0:NC];
   logic        r_wten [0:NC];
   logic [1:0]  r_wrow [0:NC];
   logic [7:0]  r_wadr [0:NC];
   logic [3:0]  r_rd   [0:NC];
   logic [31:0] r_rda  [0:NC];
   logic [3:0]  r_wr   [0:NC];
   logic [31:0] r_wra  [0:NC];

   // Cycle c is the c-th cycle after the edge that samples start.
   task automatic run_pass(input logic [7:0] nr, input logic [7:0] bin,
                           input logic [7:0] bout, input logic [7:0] bwt,
                           input bit hold);
      @(negedge clk);
      bus.start = 1'b1;
      bus.num_rows = nr;
      bus.base_in_addr = bin;
      bus.base_out_addr = bout;
      bus.base_wt_addr = bwt;
      for (int c = 1; c <= NC; c++) begin
         @(negedge clk);
         r_busy[c] = bus.busy;
         r_done[c] = bus.done;
         r_wten[c] = bus.wt_en;
         r_wrow[c] = bus.wt_row;
         r_wadr[c] = bus.wt_addr;
         r_rd[c]   = bus.rd_en;
         r_rda[c]  = bus.rd_addr;
         r_wr[c]   = bus.wr_en;
         r_wra[c]  = bus.wr_addr;
         if (!hold) bus.start = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.num_rows = 8'd0;
      bus.base_in_addr = 8'd0;
      bus.base_out_addr = 8'd0;
      bus.base_wt_addr = 8'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.wt_en, bus.wt_row, bus.wt_addr, bus.rd_en,
           bus.rd_addr, bus.wr_en, bus.wr_addr} !== 85'd0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b wt_en=%b rd_en=%b wr_en=%b expected all 0",
                  bus.busy, bus.done, bus.wt_en, bus.rd_en, bus.wr_en);
      end
      reset = 1'b0;
   endtask

   task automatic test_weight_load;
      int nwt;
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (r_wten[c] !== 1'b1 || r_wrow[c] !== 2'(c - 1) || r_wadr[c] !== 8'(8'h20 + c - 1)) begin
            errors++;
            $display("FAIL wload_c%0d: en=%b row=%0d addr=%h expected en=1 row=%0d addr=%h",
                     c, r_wten[c], r_wrow[c], r_wadr[c], c - 1, 8'h20 + c - 1);
         end
      end
      nwt = 0;
      for (int c = 1; c <= 17; c++) if (r_wten[c] === 1'b1) nwt++;
      checks++;
      if (nwt != 4) begin
         errors++;
         $display("FAIL wload_count: got %0d wt_en cycles expected 4", nwt);
      end
      for (int c = 1; c <= 17; c++) begin
         checks++;
         if (r_busy[c] !== (c <= 16) || r_done[c] !== (c == 16)) begin
            errors++;
            $display("FAIL busy_done_c%0d: busy=%b done=%b expected busy=%b done=%b",
                     c, r_busy[c], r_done[c], c <= 16, c == 16);
         end
      end
   endtask

   task automatic test_read_side;
      logic [3:0] exp_rd [0:10];
      exp_rd = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
      for (int t = 0; t <= 10; t++) begin
         checks++;
         if (r_rd[t + 5] !== exp_rd[t]) begin
            errors++;
            $display("FAIL rd_en_t%0d: got %b expected %b", t, r_rd[t + 5], exp_rd[t]);
         end
      end
      checks++;
      if (r_rda[5] !== 32'h0000_0010) begin
         errors++;
         $display("FAIL rd_addr_t0: got %h expected 00000010", r_rda[5]);
      end
      checks++;
      if (r_rda[8] !== 32'h1011_1213) begin
         errors++;
         $display("FAIL rd_addr_t3: got %h expected 10111213", r_rda[8]);
      end
      checks++;
      if (r_rda[11] !== 32'h1300_0000) begin
         errors++;
         $display("FAIL rd_addr_t6: got %h expected 13000000", r_rda[11]);
      end
   endtask

   task automatic test_write_side;
      logic [3:0] exp_wr [0:10];
      exp_wr = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
      for (int t = 0; t <= 10; t++) begin
         checks++;
         if (r_wr[t + 5] !== exp_wr[t]) begin
            errors++;
            $display("FAIL wr_en_t%0d: got %b expected %b", t, r_wr[t + 5], exp_wr[t]);
         end
      end
      checks++;
      if (r_wra[9] !== 32'h0000_0040) begin
         errors++;
         $display("FAIL wr_addr_t4: got %h expected 00000040", r_wra[9]);
      end
      checks++;
      if (r_wra[12] !== 32'h4041_4243) begin
         errors++;
         $display("FAIL wr_addr_t7: got %h expected 40414243", r_wra[12]);
      end
      checks++;
      if (r_wra[15] !== 32'h4300_0000) begin
         errors++;
         $display("FAIL wr_addr_t10: got %h expected 43000000", r_wra[15]);
      end
   endtask

   task automatic test_wrap_zero;
      logic [7:0] exp_a [0:2];
      int nb;
      exp_a = '{8'hFE, 8'hFF, 8'h00};
      run_pass(8'd3, 8'hFE, 8'h40, 8'h20, 1'b0);
      for (int t = 0; t <= 2; t++) begin
         checks++;
         if (r_rd[t + 5][0] !== 1'b1 || r_rda[t + 5][7:0] !== exp_a[t]) begin
            errors++;
            $display("FAIL wrap_lane0_t%0d: en=%b addr=%h expected en=1 addr=%h",
                     t, r_rd[t + 5][0], r_rda[t + 5][7:0], exp_a[t]);
         end
      end
      checks++;
      if (r_done[15] !== 1'b1 || r_done[14] !== 1'b0 || r_busy[16] !== 1'b0) begin
         errors++;
         $display("FAIL wrap_done: done14=%b done15=%b busy16=%b expected 0 1 0",
                  r_done[14], r_done[15], r_busy[16]);
      end
      run_pass(8'd0, 8'h10, 8'h40, 8'h20, 1'b0);
      nb = 0;
      for (int c = 1; c <= NC; c++) if (r_busy[c] !== 1'b0 || r_done[c] !== 1'b0) nb++;
      checks++;
      if (nb != 0) begin
         errors++;
         $display("FAIL zero_rows: %0d cycles with busy/done set expected 0", nb);
      end
   endtask

   task automatic test_start_held;
      int nd;
      run_pass(8'd4, 8'h10, 8'h40, 8'h20, 1'b1);
      nd = 0;
      for (int c = 1; c <= 17; c++) if (r_done[c] === 1'b1) nd++;
      checks++;
      if (nd != 1 || r_done[16] !== 1'b1) begin
         errors++;
         $display("FAIL held_done: %0d pulses done16=%b expected 1 pulse at cycle 16", nd, r_done[16]);
      end
      checks++;
      if (r_busy[17] !== 1'b0 || r_busy[18] !== 1'b1 || r_wten[18] !== 1'b1 || r_wrow[18] !== 2'd0) begin
         errors++;
         $display("FAIL held_restart: busy17=%b busy18=%b wt_en18=%b row18=%0d expected 0 1 1 0",
                  r_busy[17], r_busy[18], r_wten[18], r_wrow[18]);
      end
      bus.start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_run;
      int bad;
      @(negedge clk);
      bus.start = 1'b1;
      bus.num_rows = 8'd4;
      bus.base_in_addr = 8'h10;
      bus.base_out_addr = 8'h40;
      bus.base_wt_addr = 8'h20;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      checks++;
      if (bus.rd_en !== 4'hC || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_run_t5: rd_en=%b busy=%b expected 1100 1", bus.rd_en, bus.busy);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({bus.busy, bus.done, bus.wt_en, bus.wt_row, bus.wt_addr, bus.rd_en,
           bus.rd_addr, bus.wr_en, bus.wr_addr} !== 85'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: busy=%b rd_en=%b wr_en=%b rd_addr=%h expected all 0",
                  bus.busy, bus.rd_en, bus.wr_en, bus.rd_addr);
      end
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_reset_quiet: %0d cycles busy/done after abort expected 0", bad);
      end
      run_pass(8'd4, 8'h10, 8'h40, 8'h20, 1'b0);
      checks++;
      if (r_done[16] !== 1'b1 || r_done[15] !== 1'b0 || r_busy[17] !== 1'b0) begin
         errors++;
         $display("FAIL rerun_done: done15=%b done16=%b busy17=%b expected 0 1 0",
                  r_done[15], r_done[16], r_busy[17]);
      end
      checks++;
      if (r_rd[8] !== 4'hF || r_rda[8] !== 32'h1011_1213 || r_wra[12] !== 32'h4041_4243) begin
         errors++;
         $display("FAIL rerun_addr: rd_en=%b rd_addr=%h wr_addr=%h expected 1111 10111213 40414243",
                  r_rd[8], r_rda[8], r_wra[12]);
      end
   endtask

   initial begin
      test_reset();
      run_pass(8'd4, 8'h10, 8'h40, 8'h20, 1'b0);
      test_weight_load();
      test_read_side();
      test_write_side();
      test_wrap_zero();
      test_start_held();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mmu_sequencer.md
Name: mmu_sequencer

Overview:
- Top-level scheduler for one matrix-multiply pass on the WIDTH_HEIGHT x WIDTH_HEIGHT systolic array.
- On start, it preloads weights row by row, then streams input vectors from the banked input memory with a per-lane diagonal skew. It then writes array outputs to the banked output memory with the matching skew and pulses done.
- Sits between the host/command interface and the memory arrays plus the array weight-load port.

Parameters:
- WIDTH_HEIGHT, 4, array dimension; number of memory banks/lanes.
- ADDR_W, 8, per-bank address width.
- ARRAY_LAT, 4, cycles from a lane's read enable to the same lane's valid output at the array bottom.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  request one pass; accepted only in IDLE
- num_rows  input  ADDR_W  number of input vectors per lane; latched on accept
- base_in_addr  input  ADDR_W  first input address, all banks; latched
- base_out_addr  input  ADDR_W  first output address, all banks; latched
- base_wt_addr  input  ADDR_W  first weight address; latched
- busy  output  1  high from WLOAD through DONE inclusive
- done  output  1  one-cycle pulse at pass end
- wt_en  output  1  weight-row load strobe to array and weight memory
- wt_row  output  clog2(WIDTH_HEIGHT)  array row being loaded
- wt_addr  output  ADDR_W  weight memory address
- rd_en  output  WIDTH_HEIGHT  per-bank input read enable, bit k = lane k
- rd_addr  output  WIDTH_HEIGHT*ADDR_W  per-bank read address, lane k in bits [k*ADDR_W +: ADDR_W]
- wr_en  output  WIDTH_HEIGHT  per-bank output write enable
- wr_addr  output  WIDTH_HEIGHT*ADDR_W  per-bank write address, same packing as rd_addr

Behaviour:
- Reset (reset is synchronous, active-high; clock is clk):
  - State goes to IDLE. All outputs 0 on the following cycle; counters cleared.
  - Reset mid-pass aborts immediately: no done pulse, no further enables.
- Outputs are decoded from registered state and counter only; there is no combinational path from any input to any output.
- States: IDLE -> WLOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 with num_rows!=0: latch all inputs and go to WLOAD.
  - start with num_rows==0: ignored; stay IDLE, no done.
  - start is ignored in every state except IDLE.
- WLOAD (counter i = 0..WIDTH_HEIGHT-1, one cycle each):
  - wt_en=1, wt_row=i, wt_addr=base_wt_addr+i.
  - After i=WIDTH_HEIGHT-1, go to RUN with t=0.
- RUN (counter t = 0..T-1, where T = num_rows + ARRAY_LAT + WIDTH_HEIGHT - 1):
  - rd_en[k]=1 iff k <= t < k+num_rows; rd_addr lane k = base_in_addr + (t-k).
  - wr_en[k]=1 iff k+ARRAY_LAT <= t < k+ARRAY_LAT+num_rows; wr_addr lane k = base_out_addr + (t-k-ARRAY_LAT).
  - Address fields of disabled lanes are driven 0.
  - After t=T-1, go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. A start in this cycle is ignored.
- Arithmetic:
  - Addresses wrap modulo 2^ADDR_W; no error is flagged.
  - The t counter is at least ADDR_W+2 bits wide so T never overflows at num_rows = 2^ADDR_W - 1.
- rd_en therefore forms a staircase: ramps 0001 -> 0011 -> ... -> all ones, holds, then ramps down to 1000 pattern. wr_en follows the same shape delayed by ARRAY_LAT.
- Total latency from accepted start to done = 1 + WIDTH_HEIGHT + T cycles. done appears on the cycle after the last RUN cycle.

Test Plan:
- Defaults, num_rows=4, base_wt=0x20, base_in=0x10, base_out=0x40, start pulse at cycle 0 -> cycles 1-4: wt_en=1, wt_row 0..3, wt_addr 0x20..0x23. RUN occupies cycles 5-15 (T=11). done at cycle 16. busy low at cycle 17.
- Same run, read side -> t=0: rd_en=0001, lane0 addr 0x10. t=3: rd_en=1111, lanes0..3 addr 0x13,0x12,0x11,0x10. t=6: rd_en=1000, lane3 addr 0x13. t>=7: rd_en=0000.
- Same run, write side -> wr_en lane0 at t=4..7 with addr 0x40..0x43. Lane3 at t=7..10 with addr 0x40..0x43. t=7: wr_en=1111.
- Wrap and zero -> base_in=0xFE, num_rows=3: lane0 addresses 0xFE, 0xFF, 0x00. Separately, start with num_rows=0: busy stays 0 and no done.
- Start while busy -> start held high through a pass: exactly one pass runs and exactly one done pulse. A second pass begins only when start is seen again in IDLE.
- Reset mid-RUN at t=5 -> next cycle all outputs 0 and state IDLE, no done. A new start then runs a full, correct pass.
